// File: rtl/mcp_pkg.sv
// mcp_pkg: shared multi-cycle core definitions (opcodes, funct3 sizes, responder states)
package mcp_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
endpackage

// File: rtl/mcp_lane_align.sv
// mcp_lane_align: byte-lane store merge and load extract/extend for a 32-bit little-endian word
//   off        byte offset within the word (addr[1:0])
//   funct3     access size/sign
//   wdata      right-justified store data
//   word       current contents of the addressed word
//   merged     word with the store lanes replaced
//   rdata      extracted, extended load data (0 for illegal funct3)
//   misaligned H/HU at odd offset or W at nonzero offset
module mcp_lane_align
  import mcp_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [31:0] merged,
  output logic [31:0] rdata,
  output logic        misaligned
);
  logic [3:0]  be;
  logic [31:0] wsh;
  logic [15:0] sh;
  always_comb begin
    wsh = wdata << {off, 3'b000};
    be = funct3[1:0] == 2'b00 ? 4'b0001 << off : funct3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
    merged = word;
    for (int i = 0; i < 4; i++) merged[i*8 +: 8] = be[i] ? wsh[i*8 +: 8] : word[i*8 +: 8];
    sh = 16'(word >> {off, 3'b000});
    rdata = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
            funct3 == F3_H  ? {{16{sh[15]}}, sh} :
            funct3 == F3_BU ? {24'd0, sh[7:0]} :
            funct3 == F3_HU ? {16'd0, sh} :
            funct3 == F3_W  ? word : '0;
    misaligned = (funct3[1:0] == 2'b01 && off[0]) || (funct3[1:0] == 2'b10 && off != 2'b00);
  end
endmodule

// File: rtl/mcp_mem_responder.sv
// mcp_mem_responder: single-outstanding memory responder with wait states, lane alignment and error flagging
//   clk, rst (sync, active-low)
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_funct3  request (accepted only in IDLE)
//   rsp_valid/rsp_rdata/rsp_err                                one-cycle response
module mcp_mem_responder
  import mcp_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state, state_n;
  logic [3:0] cnt;
  logic we_q;
  logic [31:0] addr_q, wdata_q;
  logic [2:0] f3_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic we, err, go, misaligned;
  logic [31:0] addr, wdata, word, merged, rdata;
  logic [2:0] f3;
  logic [AW-1:0] idx;
  assign req_ready = state == ST_IDLE;
  assign rsp_valid = state == ST_RESP;
  // With no wait states the response is computed on the accepting edge, before the latch holds the request.
  assign we = req_ready ? req_we : we_q;
  assign addr = req_ready ? req_addr : addr_q;
  assign wdata = req_ready ? req_wdata : wdata_q;
  assign f3 = req_ready ? req_funct3 : f3_q;
  assign idx = addr[AW+1:2];
  assign word = mem[idx];
  assign err = misaligned || addr >= 32'(4 * DEPTH_WORDS) || f3 inside {3'b011, 3'b110, 3'b111} || (we && f3[2]);
  assign go = state_n == ST_RESP;
  mcp_lane_align u_align (
    .off(addr[1:0]),
    .funct3(f3),
    .wdata(wdata),
    .word(word),
    .merged(merged),
    .rdata(rdata),
    .misaligned(misaligned)
  );
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (req_valid) state_n = WAIT_CYCLES > 0 ? ST_WAIT : ST_RESP;
      ST_WAIT: if (cnt == 4'(WAIT_CYCLES - 1)) state_n = ST_RESP;
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state == ST_WAIT ? cnt + 4'd1 : 4'd0;
      rsp_rdata <= go && !we && !err ? rdata : '0;
      rsp_err <= go && err;
    end
  end
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      we_q <= req_we;
      addr_q <= req_addr;
      wdata_q <= req_wdata;
      f3_q <= req_funct3;
    end
  end
  // The store lands on the edge that enters RESP; a reset on that edge abandons it.
  always_ff @(posedge clk) if (rst && go && we && !err) mem[idx] <= merged;
endmodule

// File: tb/tb_mcp_mem_responder.sv
// tb_mcp_mem_responder: random and directed checks of two responders (0 and 3 wait states) against a byte-array model
module tb_mcp_mem_responder;
  import mcp_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] rst, req_valid, req_ready, req_we, rsp_valid, rsp_err;
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [31:0] rsp_rdata [2];
  logic [2:0] req_funct3 [2];
  logic [7:0] mb [2][4096];
  int n_chk = 0;
  int n_fail = 0;
  mcp_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );
  mcp_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );
  function automatic int wc(input int d);
    return d == 1 ? 3 : 0;
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Reference: memory as bytes, access = size consecutive bytes starting at addr.
  task automatic model(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, output logic [31:0] rd, output logic er);
    int size;
    logic [31:0] v;
    size = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
    er = f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 || (we && (f3 == F3_BU || f3 == F3_HU))
         || a % size != 0 || a >= 4096;
    rd = 0;
    if (er) return;
    if (we) begin
      for (int i = 0; i < size; i++) mb[d][a + i] = wd[8*i +: 8];
      return;
    end
    v = 0;
    for (int i = 0; i < size; i++) v = v | (32'(mb[d][a + i]) << (8 * i));
    if (f3 == F3_B && v[7]) v = v | 32'hFFFFFF00;
    if (f3 == F3_H && v[15]) v = v | 32'hFFFF0000;
    rd = v;
  endtask
  task automatic xact(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] f3, input bit hold, output logic [31:0] rd, output logic er);
    logic [31:0] mrd;
    logic mer;
    int n;
    model(d, we, a, wd, f3, mrd, mer);
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d] = we;
    req_addr[d] = a;
    req_wdata[d] = wd;
    req_funct3[d] = f3;
    check("ready_idle", req_ready[d], 1);
    n = 0;
    while (!rsp_valid[d] && n < 40) begin
      @(negedge clk);
      if (!hold) req_valid[d] = 1'b0;
      n++;
      if (!rsp_valid[d]) check("quiet_wait", {req_ready[d], rsp_err[d], rsp_rdata[d]}, 0);
    end
    check("latency", n, 1 + wc(d));
    check("rdata", rsp_rdata[d], mrd);
    check("err", rsp_err[d], mer);
    check("ready_resp", req_ready[d], 0);
    rd = rsp_rdata[d];
    er = rsp_err[d];
  endtask
  task automatic rand_xact(input int d);
    logic [31:0] a, rd;
    logic er;
    int r;
    r = $urandom_range(0, 19);
    a = r == 0 ? 32'h1000 + $urandom_range(0, 255) : r == 1 ? $urandom : 32'($urandom_range(0, 1023));
    xact(d, 1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)), 0, rd, er);
  endtask
  initial begin
    logic [31:0] rd;
    logic er;
    rst = 2'b00;
    req_valid = 2'b00;
    req_we = 2'b00;
    for (int d = 0; d < 2; d++) begin
      req_addr[d] = 0;
      req_wdata[d] = 0;
      req_funct3[d] = F3_W;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++)
      check("reset_state", {req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d]}, 64'h4_0000_0000);
    rst = 2'b11;
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 256; w++) xact(d, 1'b1, 32'(w * 4), $urandom, F3_W, 0, rd, er);
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, F3_W, 0, rd, er);
    xact(0, 1'b0, 32'h10, 0, F3_W, 0, rd, er);
    check("lw_10", {er, rd}, 33'h0DEADBEEF);
    xact(0, 1'b1, 32'h20, 32'h80FF7F01, F3_W, 0, rd, er);
    xact(0, 1'b0, 32'h22, 0, F3_B, 0, rd, er);
    check("lb_22", rd, 32'hFFFFFFFF);
    xact(0, 1'b0, 32'h22, 0, F3_BU, 0, rd, er);
    check("lbu_22", rd, 32'h000000FF);
    xact(0, 1'b0, 32'h22, 0, F3_H, 0, rd, er);
    check("lh_22", rd, 32'hFFFF80FF);
    xact(0, 1'b0, 32'h22, 0, F3_HU, 0, rd, er);
    check("lhu_22", rd, 32'h000080FF);
    xact(0, 1'b0, 32'h20, 0, F3_B, 0, rd, er);
    check("lb_20", rd, 32'h00000001);
    xact(0, 1'b1, 32'h20, 32'h11223344, F3_W, 0, rd, er);
    xact(0, 1'b1, 32'h21, 32'h000000AA, F3_B, 0, rd, er);
    xact(0, 1'b0, 32'h20, 0, F3_W, 0, rd, er);
    check("sb_21", rd, 32'h1122AA44);
    xact(0, 1'b1, 32'h22, 32'h0000BEEF, F3_H, 0, rd, er);
    xact(0, 1'b0, 32'h20, 0, F3_W, 0, rd, er);
    check("sh_22", rd, 32'hBEEFAA44);
    xact(0, 1'b0, 32'h13, 0, F3_W, 0, rd, er);
    check("lw_mis", {er, rd}, 33'h100000000);
    xact(0, 1'b0, 32'h15, 0, F3_H, 0, rd, er);
    check("lh_mis", {er, rd}, 33'h100000000);
    xact(0, 1'b1, 32'h1000, 32'h12345678, F3_W, 0, rd, er);
    check("sw_oor", {er, rd}, 33'h100000000);
    xact(0, 1'b1, 32'h20, 32'h12345678, F3_BU, 0, rd, er);
    check("sw_f3", {er, rd}, 33'h100000000);
    xact(0, 1'b0, 32'h20, 0, F3_W, 0, rd, er);
    check("ram_kept", rd, 32'hBEEFAA44);
    xact(1, 1'b1, 32'h80, 32'h5A5AA5A5, F3_W, 1, rd, er);
    xact(1, 1'b1, 32'h80, 32'h5A5AA5A5, F3_W, 0, rd, er);
    xact(1, 1'b0, 32'h80, 0, F3_W, 0, rd, er);
    check("held_req", rd, 32'h5A5AA5A5);
    xact(1, 1'b1, 32'h40, 32'h0, F3_W, 0, rd, er);
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_we[1] = 1'b1;
    req_addr[1] = 32'h40;
    req_wdata[1] = 32'hCAFEF00D;
    req_funct3[1] = F3_W;
    check("ready_pre_rst", req_ready[1], 1);
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("busy_pre_rst", {req_ready[1], rsp_valid[1]}, 0);
    @(negedge clk);
    rst[1] = 1'b0;
    check("busy_rst", {req_ready[1], rsp_valid[1]}, 0);
    @(negedge clk);
    rst[1] = 1'b1;
    check("after_rst", {req_ready[1], rsp_valid[1], rsp_err[1], rsp_rdata[1]}, 64'h4_0000_0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_rsp_after_rst", rsp_valid[1], 0);
    end
    xact(1, 1'b0, 32'h40, 0, F3_W, 0, rd, er);
    check("store_abandoned", rd, 32'h0);
    for (int i = 0; i < 300; i++) begin
      rand_xact(0);
      rand_xact(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
